// File: rtl/frame_deser_pkg.sv
// Shared types and helpers for the frame deserializer.
//   state_e         : FSM state encoding (PARITY is only reachable in the
//                     parity-checking build).
//   even_parity_ok  : returns 1 when data plus parity bit hold an even
//                     number of ones. Data is passed zero-extended to 64 bits,
//                     which leaves the parity of any narrower word unchanged.
package frame_deser_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_e;

    function automatic logic even_parity_ok(input logic [63:0] data, input logic parity_bit);
        return ((^data) ^ parity_bit) == 1'b0;
    endfunction

endpackage

// File: rtl/frame_deserializer.sv
// frame_deserializer: assembles a framed serial bit stream into WIDTH-bit words.
//
// Optional feature macro: FRAME_DESER_PARITY_EN
//   defined   : after the WIDTH data bits one parity bit is collected; the
//               word is delivered only if data plus parity has even parity,
//               otherwise err_o pulses and data_o keeps its old value.
//   undefined : the frame ends after WIDTH data bits.
//
// Parameters:
//   WIDTH      word width in bits (2..64)
//   MSB_FIRST  1: first serial bit lands in data_o[WIDTH-1]; 0: in data_o[0]
//
// Ports:
//   clk_i        clock, all logic on the rising edge
//   rst_ni       synchronous reset, active HIGH despite the name
//   start_i      frame-start marker (carries no data bit)
//   bit_valid_i  bit_i holds a serial bit this cycle
//   bit_i        serial data bit
//   valid_o      one-cycle strobe: data_o holds a new word
//   data_o       last completed word, held between strobes
//   err_o        one-cycle strobe: frame aborted or parity failed
module frame_deserializer
    import frame_deser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             bit_valid_i,
    input  logic             bit_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             err_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    state_e           state_r, state_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic [WIDTH-1:0] shift_r, shift_s;
    logic [WIDTH-1:0] data_r, data_s;
    logic             valid_r, valid_s;
    logic             err_r, err_s;

    logic [WIDTH-1:0] shifted_s;
    logic             last_bit_s;

    assign valid_o = valid_r;
    assign data_o  = data_r;
    assign err_o   = err_r;

    // Counter holds the number of data bits already accepted, so the
    // incoming bit completes the word when it equals WIDTH-1.
    assign last_bit_s = (cnt_r == LAST_IDX);

    // Shift register contents with the current bit_i inserted.
    always_comb begin
        if (MSB_FIRST) begin
            shifted_s = {shift_r[WIDTH-2:0], bit_i};
        end else begin
            shifted_s = {bit_i, shift_r[WIDTH-1:1]};
        end
    end

    // Next-state, counter, shift register and output strobe logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        shift_s = shift_r;
        data_s  = data_r;
        valid_s = 1'b0;
        err_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_i) begin
                    state_s = SHIFT;
                    cnt_s   = {CW{1'b0}};
                    shift_s = {WIDTH{1'b0}};
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
`ifdef FRAME_DESER_PARITY_EN
                // The last data bit does not end the frame here, so a start
                // alongside it is still an abort.
                if (start_i) begin
                    err_s   = 1'b1;
                    state_s = SHIFT;
                    cnt_s   = {CW{1'b0}};
                    shift_s = {WIDTH{1'b0}};
                end else if (bit_valid_i) begin
                    shift_s = shifted_s;
                    cnt_s   = cnt_r + CW'(1);
                    if (last_bit_s) begin
                        state_s = PARITY;
                    end else begin
                        state_s = SHIFT;
                    end
                end else begin
                    state_s = SHIFT;
                end
`else
                if (bit_valid_i && last_bit_s) begin
                    // Completing bit wins over a coincident start: deliver
                    // the word and, if start_i is high, open the next frame.
                    data_s  = shifted_s;
                    valid_s = 1'b1;
                    cnt_s   = {CW{1'b0}};
                    shift_s = {WIDTH{1'b0}};
                    state_s = start_i ? SHIFT : IDLE;
                end else if (start_i) begin
                    // Abort: any bit presented this cycle is dropped.
                    err_s   = 1'b1;
                    state_s = SHIFT;
                    cnt_s   = {CW{1'b0}};
                    shift_s = {WIDTH{1'b0}};
                end else if (bit_valid_i) begin
                    shift_s = shifted_s;
                    cnt_s   = cnt_r + CW'(1);
                    state_s = SHIFT;
                end else begin
                    state_s = SHIFT;
                end
`endif
            end
`ifdef FRAME_DESER_PARITY_EN
            PARITY: begin
                if (bit_valid_i) begin
                    if (even_parity_ok(64'(shift_r), bit_i)) begin
                        data_s  = shift_r;
                        valid_s = 1'b1;
                    end else begin
                        err_s   = 1'b1;
                    end
                    cnt_s   = {CW{1'b0}};
                    shift_s = {WIDTH{1'b0}};
                    state_s = start_i ? SHIFT : IDLE;
                end else if (start_i) begin
                    err_s   = 1'b1;
                    state_s = SHIFT;
                    cnt_s   = {CW{1'b0}};
                    shift_s = {WIDTH{1'b0}};
                end else begin
                    state_s = PARITY;
                end
            end
`endif
            default: begin
                state_s = IDLE;
                cnt_s   = {CW{1'b0}};
                shift_s = {WIDTH{1'b0}};
            end
        endcase
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
            shift_r <= {WIDTH{1'b0}};
            data_r  <= {WIDTH{1'b0}};
            valid_r <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            shift_r <= shift_s;
            data_r  <= data_s;
            valid_r <= valid_s;
            err_r   <= err_s;
        end
    end

endmodule

// File: tb/tb_frame_deserializer.sv
// Self-checking bench for frame_deserializer. Two instances (MSB-first and
// LSB-first) share one stimulus stream; a behavioural frame model pushes
// expected strobes into a queue, and every cycle the outputs are checked
// against the queue head and the expected held data.
module tb_frame_deserializer;

`ifdef FRAME_DESER_PARITY_EN
    localparam int NBITS = 9;
`else
    localparam int NBITS = 8;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_ni = 1'b1;
    logic       start_i = 1'b0;
    logic       bit_valid_i = 1'b0;
    logic       bit_i = 1'b0;
    logic       valid_m, err_m, valid_l, err_l;
    logic [7:0] data_m, data_l;

    frame_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .bit_valid_i(bit_valid_i),
        .bit_i(bit_i), .valid_o(valid_m), .data_o(data_m), .err_o(err_m)
    );

    frame_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .bit_valid_i(bit_valid_i),
        .bit_i(bit_i), .valid_o(valid_l), .data_o(data_l), .err_o(err_l)
    );

    typedef struct {
        bit         is_err;
        logic [7:0] word_m;
        logic [7:0] word_l;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;

    bit         in_frame = 1'b0;
    int         m_cnt = 0;
    logic [7:0] m_word_m = 8'h00;
    logic [7:0] m_word_l = 8'h00;
    logic [7:0] cur_m = 8'h00;
    logic [7:0] cur_l = 8'h00;

    task automatic push_exp(input bit is_err, input logic [7:0] wm, input logic [7:0] wl);
        exp_t e;
        e.is_err = is_err;
        e.word_m = wm;
        e.word_l = wl;
        e.cyc    = cyc + 1;
        exp_q.push_back(e);
    endtask

    // Per-cycle output check against the scoreboard and the held data.
    task automatic check_outputs();
        exp_t e;
        logic [3:0] strobe;
        logic [3:0] exp_strobe;
        strobe = {valid_m, err_m, valid_l, err_l};
        if (strobe !== 4'b0000) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_strobe cyc=%0d got v/e/v/e=%b required none", cyc, strobe);
            end else begin
                e = exp_q.pop_front();
                exp_strobe = e.is_err ? 4'b0101 : 4'b1010;
                if (strobe !== exp_strobe || e.cyc != cyc) begin
                    bad++;
                    $display("FAIL strobe cyc=%0d got %b required %b at cyc %0d", cyc, strobe, exp_strobe, e.cyc);
                end
                if (!e.is_err) begin
                    cur_m = e.word_m;
                    cur_l = e.word_l;
                end
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            total++;
            bad++;
            e = exp_q.pop_front();
            $display("FAIL missed_strobe cyc=%0d got none required err=%0d at cyc %0d", cyc, e.is_err, e.cyc);
            if (!e.is_err) begin
                cur_m = e.word_m;
                cur_l = e.word_l;
            end
        end
        total++;
        if (data_m !== cur_m || data_l !== cur_l) begin
            bad++;
            $display("FAIL data cyc=%0d got msb=%h lsb=%h required msb=%h lsb=%h", cyc, data_m, data_l, cur_m, cur_l);
        end
    endtask

    // One clock cycle: update the frame model, drive inputs, check outputs.
    task automatic tick(input logic s, input logic bv, input logic b);
        bit completes;
        bit ok;
        if (!rst_ni) begin
            completes = in_frame && bv && (m_cnt == NBITS - 1);
            if (in_frame && bv && (completes || !s)) begin
                if (m_cnt < 8) begin
                    m_word_m = {m_word_m[6:0], b};
                    m_word_l = {b, m_word_l[7:1]};
                end
                m_cnt++;
            end
            if (completes) begin
`ifdef FRAME_DESER_PARITY_EN
                ok = (((^m_word_m) ^ b) == 1'b0);
`else
                ok = 1'b1;
`endif
                push_exp(!ok, m_word_m, m_word_l);
            end
            if (s) begin
                if (in_frame && !completes) push_exp(1'b1, 8'h00, 8'h00);
                in_frame = 1'b1;
                m_cnt    = 0;
                m_word_m = 8'h00;
                m_word_l = 8'h00;
            end else if (completes) begin
                in_frame = 1'b0;
            end
        end
        start_i     = s;
        bit_valid_i = bv;
        bit_i       = b;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset(input int n);
        rst_ni   = 1'b1;
        in_frame = 1'b0;
        cur_m    = 8'h00;
        cur_l    = 8'h00;
        repeat (n) tick(1'b0, 1'b0, 1'b0);
        rst_ni = 1'b0;
    endtask

    // Data bits in arrival order w[7]..w[0], then the even parity bit
    // (optionally inverted) in the parity build.
    task automatic send_bits(input logic [7:0] w, input bit bubbles, input bit last_start, input bit flip_par);
        logic b;
        for (int i = 0; i < NBITS; i++) begin
            b = (i < 8) ? w[7 - i] : ((^w) ^ flip_par);
            if (bubbles && i > 0) tick(1'b0, 1'b0, ~b);
            tick(last_start && (i == NBITS - 1), 1'b1, b);
        end
    endtask

    task automatic send_word(input logic [7:0] w, input bit bubbles, input bit flip_par);
        tick(1'b1, 1'b0, 1'b0);
        send_bits(w, bubbles, 1'b0, flip_par);
    endtask

    task automatic test_reset();
        do_reset(2);
        total++;
        if (valid_m !== 1'b0 || err_m !== 1'b0 || valid_l !== 1'b0 || err_l !== 1'b0) begin
            bad++;
            $display("FAIL reset_strobes got %b%b%b%b required 0000", valid_m, err_m, valid_l, err_l);
        end
        total++;
        if (data_m !== 8'h00 || data_l !== 8'h00) begin
            bad++;
            $display("FAIL reset_data got %h/%h required 00/00", data_m, data_l);
        end
    endtask

    task automatic test_basic();
        send_word(8'hA5, 1'b0, 1'b0);
        total++;
        if (valid_m !== 1'b1 || err_m !== 1'b0 || data_m !== 8'hA5) begin
            bad++;
            $display("FAIL basic got v=%b e=%b d=%h required v=1 e=0 d=a5", valid_m, err_m, data_m);
        end
        tick(1'b0, 1'b0, 1'b0);
        total++;
        if (valid_m !== 1'b0) begin
            bad++;
            $display("FAIL basic_pulse_width got v=%b required 0", valid_m);
        end
    endtask

    task automatic test_bubbles();
        send_word(8'hA5, 1'b1, 1'b0);
        total++;
        if (valid_l !== 1'b1 || data_l !== 8'hA5) begin
            bad++;
            $display("FAIL bubbles_a5 got v=%b d=%h required v=1 d=a5", valid_l, data_l);
        end
        send_word(8'hC0, 1'b1, 1'b0);
        total++;
        if (valid_l !== 1'b1 || data_l !== 8'h03 || data_m !== 8'hC0) begin
            bad++;
            $display("FAIL bubbles_03 got lsb=%h msb=%h required lsb=03 msb=c0", data_l, data_m);
        end
    endtask

    task automatic test_abort();
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        total++;
        if (err_m !== 1'b1 || valid_m !== 1'b0 || err_l !== 1'b1) begin
            bad++;
            $display("FAIL abort_err got e=%b v=%b required e=1 v=0", err_m, valid_m);
        end
        send_bits(8'h3C, 1'b0, 1'b0, 1'b0);
        total++;
        if (valid_m !== 1'b1 || data_m !== 8'h3C) begin
            bad++;
            $display("FAIL abort_next got v=%b d=%h required v=1 d=3c", valid_m, data_m);
        end
    endtask

    task automatic test_back_to_back();
        int c1;
        tick(1'b1, 1'b0, 1'b0);
        send_bits(8'hA5, 1'b0, 1'b1, 1'b0);
        c1 = cyc;
        total++;
        if (valid_m !== 1'b1 || err_m !== 1'b0 || data_m !== 8'hA5) begin
            bad++;
            $display("FAIL b2b_first got v=%b e=%b d=%h required v=1 e=0 d=a5", valid_m, err_m, data_m);
        end
        send_bits(8'h5A, 1'b0, 1'b0, 1'b0);
        total++;
        if (valid_m !== 1'b1 || err_m !== 1'b0 || data_m !== 8'h5A || (cyc - c1) != NBITS) begin
            bad++;
            $display("FAIL b2b_second got v=%b d=%h gap=%0d required v=1 d=5a gap=%0d", valid_m, data_m, cyc - c1, NBITS);
        end
    endtask

    task automatic test_midreset();
        tick(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b1);
        do_reset(1);
        total++;
        if (valid_m !== 1'b0 || err_m !== 1'b0 || data_m !== 8'h00 || data_l !== 8'h00) begin
            bad++;
            $display("FAIL midreset got v=%b e=%b d=%h required v=0 e=0 d=00", valid_m, err_m, data_m);
        end
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 1'b1);
        total++;
        if (valid_m !== 1'b0 || data_m !== 8'h00) begin
            bad++;
            $display("FAIL midreset_ignore got v=%b d=%h required v=0 d=00", valid_m, data_m);
        end
    endtask

    task automatic test_random();
        logic [7:0] w;
        for (int k = 0; k < 6; k++) begin
            w = 8'($urandom);
            send_word(w, ($urandom_range(0, 1) == 1), 1'b0);
            total++;
            if (valid_m !== 1'b1 || data_m !== w) begin
                bad++;
                $display("FAIL random got v=%b d=%h required v=1 d=%h", valid_m, data_m, w);
            end
        end
    endtask

`ifdef FRAME_DESER_PARITY_EN
    task automatic test_parity();
        send_word(8'hA5, 1'b0, 1'b0);
        total++;
        if (valid_m !== 1'b1 || data_m !== 8'hA5) begin
            bad++;
            $display("FAIL parity_good got v=%b d=%h required v=1 d=a5", valid_m, data_m);
        end
        send_word(8'h3C, 1'b0, 1'b1);
        total++;
        if (err_m !== 1'b1 || valid_m !== 1'b0 || data_m !== 8'hA5) begin
            bad++;
            $display("FAIL parity_bad got e=%b v=%b d=%h required e=1 v=0 d=a5", err_m, valid_m, data_m);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_bubbles();
        test_abort();
        test_back_to_back();
        test_midreset();
        test_random();
`ifdef FRAME_DESER_PARITY_EN
        test_parity();
`endif
        repeat (3) tick(1'b0, 1'b0, 1'b0);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got %0d pending required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
